// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// default operand width and counter sizing.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter must hold the values 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one full-adder step per cycle,
// LSB first, behind valid/ready handshakes on both sides.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_sum_s;
    logic             fa_co_s;
    logic [WIDTH-1:0] a_shift_s;

    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_sum_s),
        .co_o (fa_co_s)
    );

    // The a register doubles as the result register: each sum bit enters at
    // the MSB as the consumed operand bit leaves at the LSB.
    if (WIDTH == 1) begin : g_shift_w1
        assign a_shift_s = fa_sum_s;
    end else begin : g_shift_wn
        assign a_shift_s = {fa_sum_s, a_q[WIDTH-1:1]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_shift_s;
                b_d     = b_q >> 1'b1;
                carry_d = fa_co_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = a_shift_s;
                    cout_d  = fa_co_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
        .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
        .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Junk on the operand inputs while the block is not idle.
    task automatic scramble8();
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
    endtask

    // One complete WIDTH=8 transaction checked against plain arithmetic.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int stall, input bit junk);
        logic [8:0] exp;
        int n;
        exp = 9'(a) + 9'(b) + 9'(c);
        chk("op8_ready_idle", 32'(ir8), 32'd1);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
        tick();
        n = 1;
        iv8 = junk;
        scramble8();
        chk("op8_busy_run", 32'(busy8), 32'd1);
        chk("op8_ready_run", 32'(ir8), 32'd0);
        while (!ov8 && n < 20) begin
            tick();
            n++;
            scramble8();
        end
        chk("op8_latency", 32'(n), 32'd9);
        chk("op8_result", 32'({cout8, sum8}), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            tick();
            scramble8();
            chk("op8_hold_result", 32'({cout8, sum8}), 32'(exp));
            chk("op8_hold_valid", 32'(ov8), 32'd1);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("op8_released", 32'(ov8), 32'd0);
        chk("op8_no_accept_on_release", 32'(busy8), 32'd0);
        iv8 = 1'b0;
        tick();
        chk("op8_idle_hold", 32'({cout8, sum8}), 32'(exp));
    endtask

    initial begin
        logic [8:0] exp9;
        logic [1:0] exp2;
        logic [2:0] v;
        int n;

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_result", 32'({cout8, sum8}), 32'd0);

        // Overflow, stalled consumer, in_valid ignored mid-operation.
        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        op8(8'h5A, 8'h25, 1'b1, 5, 1'b0);
        op8(8'h03, 8'h04, 1'b0, 1, 1'b1);

        // Reset during the 4th RUN cycle.
        a8 = 8'hC3; b8 = 8'h5D; cin8 = 1'b1; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_run_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(ir8), 32'd1);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_out_valid", 32'(ov8), 32'd0);
        chk("mid_rst_result", 32'({cout8, sum8}), 32'd0);
        op8(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Reset wins over a same-edge accept.
        rst = 1'b1; iv8 = 1'b1;
        tick();
        rst = 1'b0; iv8 = 1'b0;
        chk("rst_priority_busy", 32'(busy8), 32'd0);
        chk("rst_priority_ready", 32'(ir8), 32'd1);

        // Back-to-back with in_valid held high throughout.
        a8 = 8'h31; b8 = 8'h42; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        tick();
        n = 1;
        a8 = 8'h9C; b8 = 8'h77; cin8 = 1'b1;
        while (!ov8 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'd9);
        chk("b2b_first_result", 32'({cout8, sum8}), 32'h073);
        tick();
        chk("b2b_gap_ready", 32'(ir8), 32'd1);
        chk("b2b_gap_busy", 32'(busy8), 32'd0);
        tick();
        chk("b2b_second_accepted", 32'(busy8), 32'd1);
        iv8 = 1'b0;
        n = 1;
        while (!ov8 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_second_latency", 32'(n), 32'd9);
        exp9 = 9'(8'h9C) + 9'(8'h77) + 9'd1;
        chk("b2b_second_result", 32'({cout8, sum8}), 32'(exp9));
        tick();
        or8 = 1'b0;

        // Random transactions.
        for (int k = 0; k < 8; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(3, 0)), 1'($urandom));
        end

        // WIDTH=1 exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            exp2 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1'b1;
            tick();
            iv1 = 1'b0;
            n = 1;
            while (!ov1 && n < 10) begin
                tick();
                n++;
            end
            chk("w1_latency", 32'(n), 32'd2);
            chk("w1_result", 32'({cout1, sum1}), 32'(exp2));
            or1 = 1'b1;
            tick();
            or1 = 1'b0;
            chk("w1_released", 32'(ov1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
